// File: rtl/ets_pkg.sv
// Shared types and constants for the ETS frame sink.
// Holds the sink state encoding and the stream width / byte-enable constants.
package ets_pkg;

  localparam int ETS_DATA_W = 32;
  localparam logic [ETS_DATA_W/8-1:0] ETS_KEEP_ALL = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/ets_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Read-before-write on address collision, so a same-cycle read returns old data.
module ets_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = mem[raddr];
  end

  // Output register with reset maps onto the block-RAM output latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ets_frame_sink.sv
// AXI-Stream sink capturing one ETS frame per arm into a buffer with status and readout.
// Optional running checksum of stored beats when ETS_SINK_CHECKSUM_EN is defined.
module ets_frame_sink
  import ets_pkg::*;
#(
  parameter int DATA_W = ETS_DATA_W,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                S_AXIS_tvalid,
  output logic                S_AXIS_tready,
  input  logic [DATA_W-1:0]   S_AXIS_tdata,
  input  logic                S_AXIS_tlast,
  input  logic [DATA_W/8-1:0] S_AXIS_tkeep,
  input  logic                arm,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                keep_err,
  output logic [ADDR_W:0]     frame_len,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [31:0]         checksum
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]     FULL_LEN  = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W/8-1:0] KEEP_ALL  = '1;

  state_t            state_q, state_d;
  logic              tready_q, tready_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              overflow_q, overflow_d;
  logic              keep_err_q, keep_err_d;
  logic [ADDR_W:0]   frame_len_q, frame_len_d;
  logic              accept;
  logic              keep_bad;
  logic              we;
  logic              clr_status;

  assign accept   = S_AXIS_tvalid & tready_q;
  assign keep_bad = (S_AXIS_tkeep != KEEP_ALL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tready_q    <= 1'b0;
      wr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      keep_err_q  <= 1'b0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      wr_ptr_q    <= wr_ptr_d;
      overflow_q  <= overflow_d;
      keep_err_q  <= keep_err_d;
      frame_len_q <= frame_len_d;
    end
  end

  // Abort overrides everything: state returns to IDLE, status keeps its last value.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    overflow_d  = overflow_q;
    keep_err_d  = keep_err_q;
    frame_len_d = frame_len_q;
    we          = 1'b0;
    clr_status  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d    = CAPTURE;
            wr_ptr_d   = '0;
            overflow_d = 1'b0;
            keep_err_d = 1'b0;
            clr_status = 1'b1;
          end
        end
        CAPTURE: begin
          if (accept) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (keep_bad) keep_err_d = 1'b1;
            if (S_AXIS_tlast) begin
              state_d     = DONE;
              frame_len_d = {1'b0, wr_ptr_q} + 1'b1;
            end else if (wr_ptr_q == LAST_ADDR) begin
              state_d    = DRAIN;
              overflow_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            if (keep_bad) keep_err_d = 1'b1;
            if (S_AXIS_tlast) begin
              state_d     = DONE;
              frame_len_d = FULL_LEN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    tready_d = (state_d == CAPTURE) || (state_d == DRAIN);
  end

  always_comb begin
    busy = (state_q == CAPTURE) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  assign S_AXIS_tready = tready_q;
  assign overflow      = overflow_q;
  assign keep_err      = keep_err_q;
  assign frame_len     = frame_len_q;

  ets_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (S_AXIS_tdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef ETS_SINK_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  function automatic logic [31:0] add_mod32(input logic [31:0] acc, input logic [DATA_W-1:0] w);
    return acc + 32'(w);
  endfunction

  always_comb begin
    checksum_d = checksum_q;
    if (clr_status) begin
      checksum_d = '0;
    end else if (we) begin
      checksum_d = add_mod32(checksum_q, S_AXIS_tdata);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
